// File: rtl/hack_rom_loader.sv
// Converts the hps_io ioctl byte stream into Hack ROM word writes, zero-fills the rest of ROM and holds the CPU in reset.
// Writes land one cycle after ioctl_wr; ioctl_wait stalls hps_io only while filling. Checksum port: HACK_LOADER_CHECKSUM_EN.
module hack_rom_loader #(
    parameter int          ROM_WORDS   = 32768,
    parameter int          HOLD_CYCLES = 16,
    parameter int          SWAP_BYTES  = 1,
    parameter logic [15:0] FILL_WORD   = 16'h0000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [15:0] ioctl_dout,
    output logic        ioctl_wait,
    output logic        rom_we,
    output logic [14:0] rom_addr,
    output logic [15:0] rom_din,
    output logic        cpu_reset,
    output logic        load_done,
    output logic        overflow,
    output logic [15:0] word_count
`ifdef HACK_LOADER_CHECKSUM_EN
    ,
    output logic [15:0] checksum
`endif
);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_IDLE,
        ST_LOAD,
        ST_FILL
    } state_t;

    localparam logic [15:0] ROM_LIMIT = 16'(ROM_WORDS);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [15:0] fill_ptr_q, fill_ptr_d;
    logic        dl_prev_q;
    logic        loaded_q, loaded_d;
    logic        rom_we_q, rom_we_d;
    logic [14:0] rom_addr_q, rom_addr_d;
    logic [15:0] rom_din_q, rom_din_d;
    logic        load_done_q, load_done_d;
    logic        overflow_q, overflow_d;
    logic [15:0] word_count_q, word_count_d;
`ifdef HACK_LOADER_CHECKSUM_EN
    logic [15:0] checksum_q, checksum_d;
`endif

    logic        dl_rise;
    logic        dl_fall;
    logic [14:0] wr_word;
    logic        wr_in_range;
    logic [15:0] wr_end;
    logic [15:0] wr_data;
    logic        fill_last;
    logic        unused_addr_lsb;

    assign dl_rise     = ioctl_download & ~dl_prev_q;
    assign dl_fall     = ~ioctl_download & dl_prev_q;
    assign wr_word     = ioctl_addr[15:1];
    assign wr_in_range = (ioctl_addr[24:16] == 9'd0) && ({1'b0, wr_word} < ROM_LIMIT);
    assign wr_end      = {1'b0, wr_word} + 16'd1;
    assign wr_data     = (SWAP_BYTES != 0) ? {ioctl_dout[7:0], ioctl_dout[15:8]} : ioctl_dout;
    assign fill_last   = (fill_ptr_q + 16'd1) == ROM_LIMIT;
    // Byte lane select is meaningless for a 16-bit word stream.
    assign unused_addr_lsb = ioctl_addr[0];

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        fill_ptr_d   = fill_ptr_q;
        loaded_d     = loaded_q;
        rom_we_d     = 1'b0;
        rom_addr_d   = rom_addr_q;
        rom_din_d    = rom_din_q;
        load_done_d  = load_done_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
`ifdef HACK_LOADER_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif
        if (dl_rise) begin
            // A new download aborts whatever is running; an in-flight fill write still retires.
            state_d      = ST_LOAD;
            hold_cnt_d   = 16'd0;
            loaded_d     = 1'b0;
            load_done_d  = 1'b0;
            overflow_d   = 1'b0;
            word_count_d = 16'd0;
`ifdef HACK_LOADER_CHECKSUM_EN
            checksum_d   = 16'd0;
`endif
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = 16'd0;
                        loaded_d   = 1'b0;
                        if (loaded_q) begin
                            load_done_d = 1'b1;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 16'd1;
                    end
                end
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD: begin
                    if (ioctl_wr) begin
                        if (wr_in_range) begin
                            rom_we_d   = 1'b1;
                            rom_addr_d = wr_word;
                            rom_din_d  = wr_data;
                            if (wr_end > word_count_q) begin
                                word_count_d = wr_end;
                            end
`ifdef HACK_LOADER_CHECKSUM_EN
                            checksum_d = checksum_q + wr_data;
`endif
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    // Fill starts after any write accepted on the falling-edge cycle.
                    if (dl_fall) begin
                        state_d    = ST_FILL;
                        fill_ptr_d = word_count_d;
                    end
                end
                ST_FILL: begin
                    if (fill_ptr_q < ROM_LIMIT) begin
                        rom_we_d   = 1'b1;
                        rom_addr_d = fill_ptr_q[14:0];
                        rom_din_d  = FILL_WORD;
                        fill_ptr_d = fill_ptr_q + 16'd1;
                        if (fill_last) begin
                            state_d    = ST_HOLD;
                            hold_cnt_d = 16'd0;
                            loaded_d   = 1'b1;
                        end
                    end else begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 16'd0;
                        loaded_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HOLD;
            hold_cnt_q   <= 16'd0;
            fill_ptr_q   <= 16'd0;
            dl_prev_q    <= 1'b0;
            loaded_q     <= 1'b0;
            rom_we_q     <= 1'b0;
            rom_addr_q   <= 15'd0;
            rom_din_q    <= 16'd0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= 16'd0;
`ifdef HACK_LOADER_CHECKSUM_EN
            checksum_q   <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            fill_ptr_q   <= fill_ptr_d;
            dl_prev_q    <= ioctl_download;
            loaded_q     <= loaded_d;
            rom_we_q     <= rom_we_d;
            rom_addr_q   <= rom_addr_d;
            rom_din_q    <= rom_din_d;
            load_done_q  <= load_done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
`ifdef HACK_LOADER_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign ioctl_wait = (state_q == ST_FILL);
    assign cpu_reset  = (state_q != ST_IDLE);
    assign rom_we     = rom_we_q;
    assign rom_addr   = rom_addr_q;
    assign rom_din    = rom_din_q;
    assign load_done  = load_done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;
`ifdef HACK_LOADER_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule
